// File: rtl/viterbi_ber_checker.sv
// BER monitor for the encoder/channel/Viterbi chain: finds the decoder latency
// against the source stream, locks to it, then counts decoded bits and residual errors.
module viterbi_ber_checker #(
  parameter int MAX_LAT     = 64,
  parameter int SYNC_LEN    = 32,
  parameter int LOSS_WIN    = 64,
  parameter int LOSS_THRESH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ref_valid_i,
  input  logic                         ref_bit_i,
  input  logic                         dec_valid_i,
  input  logic                         dec_bit_i,
  input  logic                         clear_i,
  output logic                         locked_o,
  output logic [$clog2(MAX_LAT+1)-1:0] latency_o,
  output logic [31:0]                  bit_ct_o,
  output logic [31:0]                  err_ct_o,
  output logic                         err_flag_o,
  output logic                         lock_lost_o
);

  localparam int LW = $clog2(MAX_LAT+1);
  localparam int RW = $clog2(SYNC_LEN+1);
  localparam int BW = $clog2(LOSS_WIN+1);
  localparam int EW = $clog2(LOSS_THRESH+1);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [LW-1:0] LAT_MAX  = LW'(MAX_LAT);
  localparam logic [RW-1:0] RUN_LAST = RW'(SYNC_LEN-1);
  localparam logic [BW-1:0] BLK_LAST = BW'(LOSS_WIN-1);
  localparam logic [EW-1:0] ERR_TRIP = EW'(LOSS_THRESH);

  logic [MAX_LAT:1] hist;
  logic [LW-1:0]    fill;
  logic [LW-1:0]    cand;
  logic [RW-1:0]    run;
  logic [BW-1:0]    blk_cnt;
  logic [EW-1:0]    blk_err;
  logic [0:0]       state;

  logic          cand_bit, lock_bit, seek, cmp, mism;
  logic [EW-1:0] blk_err_nx;

  // hist[k] is the k-th most recent accepted ref bit as of the start of the cycle
  assign cand_bit   = hist[cand];
  assign lock_bit   = hist[latency_o];
  assign seek       = (state == SEARCH) && dec_valid_i && (fill >= cand);
  assign cmp        = (state == LOCKED) && dec_valid_i;
  assign mism       = cmp && (dec_bit_i != lock_bit);
  assign blk_err_nx = blk_err + EW'(mism);
  assign locked_o   = (state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (ref_valid_i) begin
      hist <= {hist[MAX_LAT-1:1], ref_bit_i};
      if (fill != LAT_MAX) fill <= fill + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SEARCH;
      cand        <= LW'(1);
      run         <= '0;
      latency_o   <= '0;
      blk_cnt     <= '0;
      blk_err     <= '0;
      err_flag_o  <= 1'b0;
      lock_lost_o <= 1'b0;
    end else begin
      err_flag_o  <= 1'b0;
      lock_lost_o <= 1'b0;
      case (state)
        SEARCH: begin
          if (seek) begin
            if (dec_bit_i == cand_bit) begin
              if (run == RUN_LAST) begin
                state     <= LOCKED;
                latency_o <= cand;
                run       <= '0;
              end else begin
                run <= run + RW'(1);
              end
            end else begin
              run  <= '0;
              cand <= (cand == LAT_MAX) ? LW'(1) : cand + LW'(1);
            end
          end
        end
        default: begin
          if (cmp) begin
            err_flag_o <= mism;
            // the tripping beat drops lock at once, even mid-block
            if (blk_err_nx == ERR_TRIP) begin
              state       <= SEARCH;
              lock_lost_o <= 1'b1;
              cand        <= LW'(1);
              run         <= '0;
              blk_cnt     <= '0;
              blk_err     <= '0;
            end else if (blk_cnt == BLK_LAST) begin
              blk_cnt <= '0;
              blk_err <= '0;
            end else begin
              blk_cnt <= blk_cnt + BW'(1);
              blk_err <= blk_err_nx;
            end
          end
        end
      endcase
    end
  end

  // clear has priority over a coincident compared beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_ct_o <= '0;
      err_ct_o <= '0;
    end else if (clear_i) begin
      bit_ct_o <= '0;
      err_ct_o <= '0;
    end else if (cmp) begin
      if (bit_ct_o != 32'hFFFF_FFFF) bit_ct_o <= bit_ct_o + 32'd1;
      if (mism && err_ct_o != 32'hFFFF_FFFF) err_ct_o <= err_ct_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench for viterbi_ber_checker: PRBS-7 source, delayed/corrupted decoded stream,
// lock, error counting, loss of lock, clear, async reset and latency boundaries.
module tb_viterbi_ber_checker;

  logic        clk = 1'b0, rst = 1'b0;
  logic        ref_valid = 1'b0, ref_bit = 1'b0, dec_valid = 1'b0, dec_bit = 1'b0, clear = 1'b0;
  logic        locked, err_flag, lock_lost;
  logic [6:0]  latency;
  logic [31:0] bit_ct, err_ct;

  always #5 clk = ~clk;

  viterbi_ber_checker #(.MAX_LAT(64), .SYNC_LEN(32), .LOSS_WIN(64), .LOSS_THRESH(16)) dut (
    .clk(clk), .rst(rst),
    .ref_valid_i(ref_valid), .ref_bit_i(ref_bit),
    .dec_valid_i(dec_valid), .dec_bit_i(dec_bit),
    .clear_i(clear),
    .locked_o(locked), .latency_o(latency),
    .bit_ct_o(bit_ct), .err_ct_o(err_ct),
    .err_flag_o(err_flag), .lock_lost_o(lock_lost)
  );

  int n_chk = 0, n_fail = 0;
  bit acc [0:32767];
  int m = 0;
  logic [6:0] lfsr = 7'h7F;
  int exp_lat = 0, exp_bits = 0, exp_errs = 0, flags = 0, losts = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // one cycle: optional ref beat, dec beat = accepted ref bit d beats back (optionally flipped)
  task automatic beat(input bit rv, input int d, input bit flip, input bit clr);
    bit was_locked, mism;
    ref_valid = rv;
    ref_bit   = lfsr[6];
    dec_valid = (m >= d);
    dec_bit   = 1'b0;
    if (m >= d) dec_bit = acc[m-d] ^ flip;
    clear = clr;
    was_locked = locked;
    mism = 1'b0;
    if (dec_valid && m >= exp_lat) mism = (dec_bit != acc[m-exp_lat]);
    if (rv) begin
      acc[m] = lfsr[6];
      m++;
      lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
    @(posedge clk); #1;
    if (clr) begin
      exp_bits = 0;
      exp_errs = 0;
    end else if (dec_valid && was_locked) begin
      exp_bits++;
      if (mism) exp_errs++;
    end
    if (err_flag) flags++;
    if (lock_lost) losts++;
    clear = 1'b0;
  endtask

  task automatic restart();
    rst = 1'b0; ref_valid = 1'b0; dec_valid = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    m = 0; exp_bits = 0; exp_errs = 0; flags = 0; losts = 0;
  endtask

  task automatic wait_lock(input int d, input int maxb, input bit gap);
    int k = 0;
    while (!locked && k < maxb) begin
      beat(gap ? (k % 3 != 1) : 1'b1, d, 1'b0, 1'b0);
      k++;
    end
    check($sformatf("lock_d%0d", d), locked, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    restart();
    check("rst_locked", locked, 0);
    check("rst_latency", latency, 0);
    check("rst_bit_ct", bit_ct, 0);
    check("rst_err_ct", err_ct, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_lock_lost", lock_lost, 0);

    // error-free delay 20
    exp_lat = 20;
    for (int k = 0; k < 1000; k++) beat(1'b1, 20, 1'b0, 1'b0);
    check("t1_locked", locked, 1);
    check("t1_latency", latency, 20);
    check("t1_err_ct", err_ct, 0);
    check("t1_bit_ct", bit_ct, exp_bits);

    // every 16th decoded bit flipped
    flags = 0; losts = 0;
    for (int k = 0; k < 640; k++) beat(1'b1, 20, (k % 16 == 15), 1'b0);
    check("t2_err_ct", err_ct, 40);
    check("t2_flags", flags, 40);
    check("t2_locked", locked, 1);
    check("t2_lost", losts, 0);
    check("t2_bit_ct", bit_ct, exp_bits);

    // decoder delay jumps to 35
    losts = 0;
    for (int k = 0; k < 96 && losts == 0; k++) beat(1'b1, 35, 1'b0, 1'b0);
    check("t3_lost", losts, 1);
    check("t3_locked", locked, 0);
    check("t3_latency_hold", latency, 20);
    check("t3_bit_ct", bit_ct, exp_bits);
    check("t3_err_ct", err_ct, exp_errs);
    exp_lat = 35;
    wait_lock(35, 3000, 1'b0);
    check("t3_relatency", latency, 35);
    check("t3_lost_once", losts, 1);

    // clear coincident with a mismatched beat
    for (int k = 0; k < 10; k++) beat(1'b1, 35, 1'b0, 1'b0);
    beat(1'b1, 35, 1'b1, 1'b1);
    check("t4_bit_ct", bit_ct, 0);
    check("t4_err_ct", err_ct, 0);
    check("t4_err_flag", err_flag, 1);
    check("t4_locked", locked, 1);
    for (int k = 0; k < 5; k++) beat(1'b1, 35, 1'b0, 1'b0);
    check("t4_bit_ct_after", bit_ct, 5);
    check("t4_err_ct_after", err_ct, 0);

    // asynchronous reset while locked, no clock edge
    beat(1'b1, 35, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t5_locked", locked, 0);
    check("t5_latency", latency, 0);
    check("t5_bit_ct", bit_ct, 0);
    check("t5_err_ct", err_ct, 0);
    check("t5_err_flag", err_flag, 0);
    restart();
    exp_lat = 20;
    wait_lock(20, 3000, 1'b0);
    check("t5_relatency", latency, 20);

    // latency boundaries
    restart();
    exp_lat = 1;
    wait_lock(1, 3000, 1'b0);
    check("t6_latency_1", latency, 1);

    restart();
    exp_lat = 64;
    wait_lock(64, 3000, 1'b0);
    check("t6_latency_64", latency, 64);

    restart();
    seen = 0;
    for (int k = 0; k < 10000; k++) begin
      beat(1'b1, 65, 1'b0, 1'b0);
      if (locked) seen = 1;
    end
    check("t6_no_lock_65", seen, 0);

    restart();
    exp_lat = 5;
    wait_lock(5, 3000, 1'b1);
    check("t6_latency_gap5", latency, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_checker.md
# viterbi_ber_checker

Receive-end bit-error-rate monitor for the convolutional encoder / channel / Viterbi decoder test chain. It taps the source bit stream fed into the encoder and the decoded bit stream leaving the decoder. It discovers the decoder latency automatically, locks to it, and counts the decoded bits and residual bit errors. It is the measuring counterpart of the channel error injector, used to confirm that injected channel errors are corrected.

## Interface
Parameters:
- MAX_LAT, 64: largest decoder latency searched, in accepted reference beats.
- SYNC_LEN, 32: consecutive matching beats required to lock.
- LOSS_WIN, 64: size of the lock-supervision block, in compared beats.
- LOSS_THRESH, 16: mismatches within one block that force loss of lock.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- ref_valid_i  in  1  source bit valid; same strobe that drives the encoder enable
- ref_bit_i  in  1  source bit presented to the encoder
- dec_valid_i  in  1  decoded bit valid
- dec_bit_i  in  1  decoded bit
- clear_i  in  1  synchronous clear of the statistics counters
- locked_o  out  1  alignment found
- latency_o  out  $clog2(MAX_LAT+1)  locked latency L, range 1..MAX_LAT
- bit_ct_o  out  32  decoded beats compared while locked
- err_ct_o  out  32  mismatched beats while locked
- err_flag_o  out  1  one-cycle pulse per mismatched locked beat
- lock_lost_o  out  1  one-cycle pulse on a LOCKED->SEARCH transition

## Operation
History register:
- MAX_LAT-deep shift register hist[1..MAX_LAT].
- On ref_valid_i, ref_bit_i enters hist[1] at the clock edge; older bits shift toward hist[MAX_LAT].
- A fill counter, saturating at MAX_LAT, counts accepted reference bits.
- Comparisons in a cycle use the hist values held at the start of that cycle. hist[L] is the L-th most recent reference bit accepted before the current cycle.

FSM has two states: SEARCH (reset state) and LOCKED.

SEARCH:
- Candidate c starts at 1. Run counter run starts at 0.
- On a dec_valid_i beat with fill < c: beat is ignored, nothing changes.
- Otherwise, if dec_bit_i == hist[c]: run increments.
- Otherwise: run is cleared to 0, and c advances by 1, wrapping from MAX_LAT to 1.
- When the matching beat makes run equal SYNC_LEN: go to LOCKED and set latency_o = c.
- No counting takes place in SEARCH.

LOCKED:
- Each dec_valid_i beat compares dec_bit_i with hist[latency_o].
- bit_ct_o increments on every compared beat.
- On a mismatch, err_ct_o increments and err_flag_o pulses.
- Both counters saturate at 32'hFFFF_FFFF.
- A block counter counts compared beats. At the end of each LOSS_WIN-beat block, the block error count is checked and then cleared.
- Loss of lock: when the block error count reaches LOSS_THRESH, go to SEARCH immediately, with c=1, run=0, and block state cleared.
- On loss of lock, lock_lost_o pulses, locked_o drops, and latency_o holds its last value. bit_ct_o and err_ct_o hold their values; they are not cleared.

clear_i:
- Zeroes bit_ct_o and err_ct_o.
- Does not affect the FSM, the history register, or the block supervision.
- If clear_i coincides with a compared beat, clear wins: the beat is not counted, but it is still applied to block supervision.

## Timing
- Reset values: locked_o=0, latency_o=0, bit_ct_o=0, err_ct_o=0, err_flag_o=0, lock_lost_o=0. hist, fill, c, run and block state are also reset.
- Reset asserted mid-operation clears everything immediately, with no drain. Search restarts after release.
- All outputs are registered. locked_o rises in the cycle after the SYNC_LEN-th matching beat.
- Counting starts with the first dec_valid_i beat after locked_o=1. The beats that achieved lock are not counted.
- err_flag_o is high in the cycle after a mismatched beat.
- A beat that reaches LOSS_THRESH is itself counted. lock_lost_o and locked_o=0 appear in the following cycle.
- ref and dec beats in the same cycle are legal. The comparison uses the old hist; the shift takes effect at the edge.
- With continuous valids and a decoder delay of d cycles, latency_o = d. A delay of more than MAX_LAT never locks.
- Throughput: one beat per cycle on each input, with no backpressure.

## Test plan
1. Continuous PRBS-7 on ref; dec = ref delayed 20 cycles, error-free; 1000 beats -> locked_o=1, latency_o=20, err_ct_o=0, bit_ct_o equals the number of dec beats after lock.
2. Locked at latency 20; flip every 16th decoded bit for 640 beats -> err_ct_o=40, 40 err_flag_o pulses, locked_o stays 1, lock_lost_o never pulses.
3. Locked at 20, then switch the delay to 35 mid-run -> lock_lost_o pulses once within 64 beats, bit_ct_o/err_ct_o retained, relock with latency_o=35.
4. clear_i pulsed while counting, coincident with a mismatched beat -> next cycle bit_ct_o=0, err_ct_o=0, err_flag_o=1, locked_o unchanged.
5. Asynchronous rst low while LOCKED -> all outputs 0 without a clock edge; after release with delay 20, relock at latency_o=20.
6. Boundaries:
   - Delay 1 -> latency_o=1.
   - Delay MAX_LAT=64 -> latency_o=64.
   - Delay 65 -> locked_o stays 0 for 10000 beats.
   - Gapped ref_valid_i, with dec matching hist[5] -> latency_o=5.
